// File: rtl/srsystem_pkg.sv
// Shared types and constants for the serial-reception system.
// Frame layout: start, 8 data bits (MSB first), parity, stop.
package srsystem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SHIFT,
    CHECK
  } rx_state_e;

  localparam int SR_FRAME_BITS = 11;
  localparam int SR_DATA_BITS  = 8;

endpackage

// File: rtl/srsystem_tick.sv
// Oversampling tick divider; phase restarts on i_phase_clr.
// Pulses tick once every TICK_DIV rxclk cycles.
module srsystem_tick #(
  parameter int TICK_DIV = 1
) (
  input  logic rxclk,
  input  logic clr,
  input  logic phase_clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(TICK_DIV - 1));
  assign tick   = w_wrap;

  always_ff @(posedge rxclk or negedge clr) begin
    if (!clr) begin
      r_cnt <= '0;
    end else if (phase_clr || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/srsystem_rxctl.sv
// Receive controller: start detect, mid-bit shift strobes,
// frame field checks and a valid/ack output register.
module srsystem_rxctl
  import srsystem_pkg::*;
#(
  parameter int OVS      = 16,
  parameter int TICK_DIV = 1,
  parameter bit PAR_ODD  = 1'b1
) (
  input  logic                    rxclk,
  input  logic                    clr,
  input  logic                    rx,
  output logic                    rxs,
  output logic                    sh_en,
  output logic                    sr_clr_n,
  input  logic                    QST,
  input  logic                    OPn,
  input  logic                    QSP,
  input  logic [SR_DATA_BITS-1:0] Q,
  output logic [SR_DATA_BITS-1:0] dout,
  output logic                    dout_vld,
  input  logic                    dout_ack,
  output logic                    par_err,
  output logic                    frm_err,
  output logic                    ovr_err,
  output logic                    busy
);

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(SR_FRAME_BITS + 1);

  logic                    r_s1;
  logic                    r_s2;
  logic                    r_prev;
  logic                    r_clr_n;
  rx_state_e               r_state;
  rx_state_e               w_state_nx;
  logic [TW-1:0]           r_tcnt;
  logic [TW-1:0]           w_tcnt_nx;
  logic [BW-1:0]           r_bcnt;
  logic [BW-1:0]           w_bcnt_nx;
  logic [SR_DATA_BITS-1:0] r_dout;
  logic                    r_vld;
  logic                    r_par;
  logic                    r_frm;
  logic                    r_ovr;
  logic                    w_tick;
  logic                    w_fall;
  logic                    w_start;
  logic                    w_sh;
  logic                    w_check;
  logic                    w_ack;

  srsystem_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .rxclk     (rxclk),
    .clr       (clr),
    .phase_clr (w_start),
    .tick      (w_tick)
  );

  assign w_fall = r_prev & ~r_s2;
  assign w_ack  = dout_ack & r_vld;

  always_comb begin
    w_state_nx = r_state;
    w_tcnt_nx  = r_tcnt;
    w_bcnt_nx  = r_bcnt;
    w_start    = 1'b0;
    w_sh       = 1'b0;
    w_check    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nx = START;
          w_start    = 1'b1;
          w_tcnt_nx  = '0;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_tcnt == TW'(OVS / 2 - 1)) begin
            w_tcnt_nx = '0;
            if (r_s2) begin
              w_state_nx = IDLE;
            end else begin
              w_sh       = 1'b1;
              w_bcnt_nx  = BW'(1);
              w_state_nx = SHIFT;
            end
          end else begin
            w_tcnt_nx = r_tcnt + TW'(1);
          end
        end
      end
      SHIFT: begin
        if (w_tick) begin
          if (r_tcnt == TW'(OVS - 1)) begin
            w_tcnt_nx = '0;
            w_sh      = 1'b1;
            w_bcnt_nx = r_bcnt + BW'(1);
            if (r_bcnt == BW'(SR_FRAME_BITS - 1)) begin
              w_state_nx = CHECK;
            end
          end else begin
            w_tcnt_nx = r_tcnt + TW'(1);
          end
        end
      end
      CHECK: begin
        w_check    = 1'b1;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge rxclk or negedge clr) begin
    if (!clr) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_prev  <= 1'b1;
      r_clr_n <= 1'b0;
      r_state <= IDLE;
      r_tcnt  <= '0;
      r_bcnt  <= '0;
    end else begin
      r_s1    <= rx;
      r_s2    <= r_s1;
      r_prev  <= r_s2;
      r_clr_n <= ~w_start;
      r_state <= w_state_nx;
      r_tcnt  <= w_tcnt_nx;
      r_bcnt  <= w_bcnt_nx;
    end
  end

  // A new byte always wins; overrun only if the old one was never taken.
  always_ff @(posedge rxclk or negedge clr) begin
    if (!clr) begin
      r_dout <= '0;
      r_vld  <= 1'b0;
      r_par  <= 1'b0;
      r_frm  <= 1'b0;
      r_ovr  <= 1'b0;
    end else if (w_check) begin
      r_dout <= Q;
      r_vld  <= 1'b1;
      r_par  <= ((^{Q, OPn}) != PAR_ODD);
      r_frm  <= (QST != 1'b0) | (QSP != 1'b1);
      r_ovr  <= r_vld & ~w_ack;
    end else if (w_ack) begin
      r_vld  <= 1'b0;
      r_ovr  <= 1'b0;
    end
  end

  assign rxs      = r_s2;
  assign sh_en    = w_sh;
  assign sr_clr_n = r_clr_n;
  assign busy     = (r_state != IDLE);
  assign dout     = r_dout;
  assign dout_vld = r_vld;
  assign par_err  = r_par;
  assign frm_err  = r_frm;
  assign ovr_err  = r_ovr;

endmodule

// File: tb/tb_srsystem_rxctl.sv
// Bench for srsystem_rxctl with a behavioural 11-bit shift register.
// Directed and random frames checked against a frame-level model.
module tb_srsystem_rxctl;

  logic        rxclk = 1'b0;
  logic        clr;
  logic        rx;
  logic        rxs;
  logic        sh_en;
  logic        sr_clr_n;
  logic        QST;
  logic        OPn;
  logic        QSP;
  logic [7:0]  Q;
  logic [7:0]  dout;
  logic        dout_vld;
  logic        dout_ack;
  logic        par_err;
  logic        frm_err;
  logic        ovr_err;
  logic        busy;

  logic [10:0] sr;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          clr_cyc = 0;
  int          vld_cyc = 0;
  logic        vld_d = 1'b0;
  int          sh_q[$];

  always #5 rxclk = ~rxclk;

  srsystem_rxctl dut (
    .rxclk    (rxclk),
    .clr      (clr),
    .rx       (rx),
    .rxs      (rxs),
    .sh_en    (sh_en),
    .sr_clr_n (sr_clr_n),
    .QST      (QST),
    .OPn      (OPn),
    .QSP      (QSP),
    .Q        (Q),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_ack (dout_ack),
    .par_err  (par_err),
    .frm_err  (frm_err),
    .ovr_err  (ovr_err),
    .busy     (busy)
  );

  // First line bit ends up in sr[10]; first data bit in sr[9].
  always_ff @(posedge rxclk) begin
    if (!sr_clr_n) sr <= '0;
    else if (sh_en) sr <= {sr[9:0], rxs};
  end

  assign QST = sr[10];
  assign Q   = sr[9:2];
  assign OPn = sr[1];
  assign QSP = sr[0];

  always @(negedge rxclk) begin
    cyc <= cyc + 1;
    if (sh_en) sh_q.push_back(cyc);
    if (clr && !sr_clr_n) clr_cyc <= cyc;
    if (dout_vld && !vld_d) vld_cyc <= cyc;
    vld_d <= dout_vld;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic bit odd_par(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  function automatic bit exp_perr(input logic [7:0] b,
                                  input bit p);
    return (($countones(b) + int'(p)) % 2) != 1;
  endfunction

  task automatic send_frame(input logic [7:0] b,
                            input bit p,
                            input bit stp,
                            input int idle,
                            input int abort_n,
                            output bit aborted);
    logic [10:0] bits;
    int base;
    bits = {1'b0, b, p, stp};
    base = sh_q.size();
    aborted = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      rx = bits[i];
      for (int c = 0; c < 16; c++) begin
        @(negedge rxclk);
        if (abort_n > 0 &&
            (sh_q.size() - base) >= abort_n) begin
          clr = 1'b0;
          aborted = 1'b1;
          return;
        end
      end
    end
    rx = 1'b1;
    repeat (idle) @(negedge rxclk);
  endtask

  task automatic wait_vld(input string tag);
    int n;
    n = 0;
    while (!dout_vld && n < 400) begin
      @(negedge rxclk);
      n++;
    end
    chk(tag, 32'(dout_vld), 1);
  endtask

  task automatic do_ack(input string tag);
    @(negedge rxclk);
    dout_ack = 1'b1;
    @(negedge rxclk);
    dout_ack = 1'b0;
    chk(tag, 32'(dout_vld), 0);
    chk({tag, "_ovr"}, 32'(ovr_err), 0);
  endtask

  task automatic check_byte(input string tag,
                            input logic [7:0] b,
                            input bit p,
                            input bit stp,
                            input bit ovr);
    chk({tag, "_dout"}, 32'(dout), 32'(b));
    chk({tag, "_par"}, 32'(par_err),
        32'(exp_perr(b, p)));
    chk({tag, "_frm"}, 32'(frm_err), 32'(!stp));
    chk({tag, "_ovr"}, 32'(ovr_err), 32'(ovr));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rxs"}, 32'(rxs), 1);
    chk({tag, "_sh"}, 32'(sh_en), 0);
    chk({tag, "_clrn"}, 32'(sr_clr_n), 0);
    chk({tag, "_dout"}, 32'(dout), 0);
    chk({tag, "_vld"}, 32'(dout_vld), 0);
    chk({tag, "_errs"},
        32'({par_err, frm_err, ovr_err}), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int b0;
    bit ab;
    logic [7:0] rb;
    bit rp;
    bit rs;
    clr = 1'b0;
    rx = 1'b1;
    dout_ack = 1'b0;
    repeat (3) @(negedge rxclk);
    check_reset("rst");
    clr = 1'b1;
    @(negedge rxclk);
    chk("clrn_rise", 32'(sr_clr_n), 1);
    repeat (5) @(negedge rxclk);

    b0 = sh_q.size();
    send_frame(8'hA5, 1'b1, 1'b1, 20, 0, ab);
    wait_vld("a5_vld");
    chk("a5_nsh", 32'(sh_q.size() - b0), 11);
    if (sh_q.size() >= b0 + 11) begin
      chk("a5_first", 32'(sh_q[b0] - clr_cyc), 7);
      for (int i = 1; i < 11; i++)
        chk("a5_gap",
            32'(sh_q[b0 + i] - sh_q[b0 + i - 1]), 16);
      chk("a5_lat", 32'(vld_cyc - sh_q[b0]), 162);
    end
    check_byte("a5", 8'hA5, 1'b1, 1'b1, 1'b0);
    do_ack("a5_ack");

    send_frame(8'h07, 1'b1, 1'b1, 20, 0, ab);
    wait_vld("p07_vld");
    check_byte("p07", 8'h07, 1'b1, 1'b1, 1'b0);
    do_ack("p07_ack");

    send_frame(8'h3C, odd_par(8'h3C), 1'b0, 20, 0, ab);
    wait_vld("s3c_vld");
    check_byte("s3c", 8'h3C, odd_par(8'h3C), 1'b0, 1'b0);
    do_ack("s3c_ack");

    b0 = sh_q.size();
    rx = 1'b0;
    repeat (4) @(negedge rxclk);
    rx = 1'b1;
    chk("gl_busy", 32'(busy), 1);
    repeat (12) @(negedge rxclk);
    chk("gl_idle", 32'(busy), 0);
    chk("gl_nsh", 32'(sh_q.size() - b0), 0);
    repeat (10) @(negedge rxclk);

    send_frame(8'h11, odd_par(8'h11), 1'b1, 0, 0, ab);
    send_frame(8'h22, odd_par(8'h22), 1'b1, 20, 0, ab);
    wait_vld("ov_vld");
    check_byte("ov", 8'h22, odd_par(8'h22), 1'b1, 1'b1);
    do_ack("ov_ack");

    b0 = sh_q.size();
    send_frame(8'hC3, odd_par(8'hC3), 1'b1, 0, 5, ab);
    chk("ab_hit", 32'(ab), 1);
    #1;
    check_reset("ab");
    rx = 1'b1;
    repeat (3) @(negedge rxclk);
    chk("ab_nsh", 32'(sh_q.size() - b0 <= 6), 1);
    clr = 1'b1;
    @(negedge rxclk);
    chk("ab_clrn", 32'(sr_clr_n), 1);
    repeat (20) @(negedge rxclk);
    chk("ab_quiet", 32'({dout_vld, busy}), 0);

    send_frame(8'h5A, 1'b1, 1'b1, 20, 0, ab);
    wait_vld("r5a_vld");
    check_byte("r5a", 8'h5A, 1'b1, 1'b1, 1'b0);
    do_ack("r5a_ack");

    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom);
      rp = 1'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rp, rs, 20, 0, ab);
      wait_vld("rnd_vld");
      check_byte("rnd", rb, rp, rs, 1'b0);
      do_ack("rnd_ack");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=done");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/srsystem_rxctl.md
# srsystem_rxctl

Receive controller for the serial-reception system's 11-bit frame shift register (start, 8 data, odd-parity, stop).
- Detects a frame start on the serial line and times mid-bit sampling from an oversampling tick.
- Issues exactly 11 shift strobes to the shift register, then checks the captured start, parity and stop fields.
- Presents the data byte to downstream logic with a valid/ack handshake.
- Sits between the line input and the shift register; consumes the register's parallel outputs.

## Interface
- `OVS`, 16: oversampling ticks per bit; even, ≥4.
- `TICK_DIV`, 1: `rxclk` cycles per oversampling tick; ≥1.
- `PAR_ODD`, 1: 1 = odd parity (ones in Q plus OPn must be odd), 0 = even.

- `rxclk` in 1: system clock; all logic on its rising edge.
- `clr` in 1: asynchronous, active-low reset.
- `rx` in 1: raw serial line; idles high.
- `rxs` out 1: synchronized `rx`; drives the shift register's data input.
- `sh_en` out 1: one-cycle shift strobe to the shift register.
- `sr_clr_n` out 1: active-low clear to the shift register.
- `QST`, `OPn`, `QSP` in 1: start, parity and stop fields from the register.
- `Q` in 8: data field from the register.
- `dout` out 8: received byte.
- `dout_vld` out 1: byte valid; held until acknowledged.
- `dout_ack` in 1: consumer accepts the byte.
- `par_err`, `frm_err`, `ovr_err` out 1: status for the byte on `dout`.
- `busy` out 1: a frame is in progress.

## Operation
- `rx` passes through a 2-flop synchronizer to form `rxs`. A falling edge is detected on `rxs` (previous 1, current 0).
- Tick generator: free-running; pulses `tick` once every `TICK_DIV` cycles.
- States:
  - **IDLE**: wait for a falling edge on `rxs`. On the edge, go to START, clear the tick phase counter, and pulse `sr_clr_n` low for one cycle.
  - **START**: after `OVS/2` ticks (mid start bit), sample `rxs`.
    - `rxs`=1: false start; return to IDLE, no strobe.
    - `rxs`=0: pulse `sh_en`, set bit count to 1, go to SHIFT.
  - **SHIFT**: every `OVS` ticks, pulse `sh_en` and increment the bit count. The 11th strobe moves to CHECK.
  - **CHECK**: one cycle, which reads the register fields.
    - `frm_err = (QST!=0) | (QSP!=1)`.
    - `par_err = (^{Q,OPn}) != PAR_ODD`.
    - Load `dout <= Q`, set `dout_vld`, then go to IDLE.
- Line bit order: the first data bit after start lands in Q[7]. `dout` = Q unchanged, so the line is MSB-first.
- Handshake:
  - `dout_vld` clears on the cycle after `dout_ack`=1 is sampled with `dout_vld`=1.
  - `dout_ack` while `dout_vld`=0 is ignored.
- Overrun: if CHECK occurs while `dout_vld`=1 and no ack is sampled in that cycle, the new byte and flags overwrite the old ones and `ovr_err`=1. `ovr_err` clears with the next ack.
- Simultaneous CHECK and ack: the ack consumes the old byte, the new byte loads, `dout_vld` stays 1, and `ovr_err`=0.
- `busy` = 1 in START, SHIFT and CHECK.
- A falling edge during SHIFT/CHECK is ignored. The line is sampled only at mid-bit points.
- After the stop-bit sample, IDLE is entered immediately. A new start edge may be accepted from the next cycle.

## Timing
- Reset (`clr`=0): state IDLE; `rxs`=1; synchronizer flops=1; `sh_en`=0; `sr_clr_n`=0; `dout`=0; `dout_vld`=0; all error flags 0; `busy`=0.
- Once `clr` deasserts, `sr_clr_n` rises on the first rising edge of `rxclk`.
- Reset mid-frame aborts the frame with no output.
- `rx` to `rxs`: 2 cycles.
- Start edge detected at cycle E. First `sh_en` at E + (`OVS/2`)·`TICK_DIV` (±1 tick phase). Subsequent strobes are spaced exactly `OVS`·`TICK_DIV` cycles.
- The register captures on the `sh_en` cycle. Fields are valid the cycle after the 11th strobe, and that cycle is CHECK.
- `dout_vld` rises one cycle after CHECK.
- Start-edge-to-`dout_vld` with defaults: 8 + 10·16 + 2 = 170 cycles from E.
- `sr_clr_n` is low exactly one cycle, at E+1. This precedes all strobes of the frame.

## Structure
- Shared package `srsystem_pkg`:
  - state enum (IDLE, START, SHIFT, CHECK);
  - `SR_FRAME_BITS` = 11;
  - `SR_DATA_BITS` = 8.
- Sub-module `srsystem_tick`: divider producing `tick` from `TICK_DIV`. Its phase is reset by the controller on start detect.
- The controller does not contain the shift register. The bench instantiates both together.

## Test plan
- Defaults, line sends 0xA5 with parity 1 and stop 1 → 11 `sh_en` strobes spaced 16 cycles; `dout`=0xA5; `dout_vld`=1; `par_err`=0; `frm_err`=0.
- Send 0x07 with parity 1 (wrong for odd) → `dout`=0x07, `par_err`=1, `frm_err`=0.
- Send 0x3C with stop bit 0 → `frm_err`=1.
- 4-cycle low glitch on an idle line → no `sh_en`, back to IDLE, `busy` drops within 8+3 cycles.
- Two back-to-back frames 0x11 then 0x22 with `dout_ack` held 0 → `dout`=0x22 and `ovr_err`=1. An ack then clears `dout_vld` and `ovr_err`.
- Assert `clr`=0 at the 5th strobe → all outputs return to reset values. A subsequent clean 0x5A frame is received correctly.
